pipe_if_stage: RTL and testbench
================================

PIPE_IF_STAGE -- requirements
Module: pipe_if_stage

Interface
REQ-001 The block SHALL have these ports, clock and reset first; reset resetn is asynchronous, active-low; clock is clock.
  clock  input  1  rising-edge clock
  resetn  input  1  asynchronous active-low reset
  wpcir  input  1  1 = IF/ID and PC may advance; 0 = pipeline stall from ID
  pcsource  input  2  next-PC select from ID: 00 pc+4, 01 bpc, 10 rpc, 11 jpc
  bpc  input  32  branch target
  rpc  input  32  jump-register target
  jpc  input  32  jump target
  imem_req  output  1  instruction fetch request
  imem_addr  output  32  fetch address (equals pc)
  imem_ack  input  1  read data valid this cycle; sampled only while imem_req=1
  imem_rdata  input  32  instruction word
  pc  output  32  current fetch PC
  pc_plus_4  output  32  pc + 4, feeds IF/ID
  inst  output  32  instruction to IF/ID
  if_busy  output  1  1 while waiting on imem_ack

Function
REQ-002 The FSM SHALL have two states: FETCH (imem_req=1) and HOLD (instruction buffered, imem_req=0).
REQ-003 In FETCH with imem_ack=1 and wpcir=1, the PC SHALL load next_pc at the clock edge and the FSM SHALL stay in FETCH.
REQ-004 In FETCH with imem_ack=1 and wpcir=0, the block SHALL capture imem_rdata into inst_buf and go to HOLD; the PC SHALL not change.
REQ-005 In HOLD with wpcir=1, the PC SHALL load next_pc and the FSM SHALL go to FETCH; with wpcir=0 it SHALL remain in HOLD.
REQ-006 In FETCH with imem_ack=0, the PC SHALL hold, imem_addr SHALL stay stable, and if_busy SHALL be 1.
REQ-007 inst SHALL be imem_rdata in FETCH with ack=1, inst_buf in HOLD, and 32'h0 (NOP bubble) in FETCH with ack=0.
REQ-008 pc_plus_4 SHALL be pc + 32'd4, modulo 2^32; 32'hFFFFFFFC wraps to 0.
REQ-009 next_pc SHALL be the pending redirect target if pend_valid=1; otherwise it SHALL be selected by pcsource.
REQ-010 If pcsource!=00 and wpcir=1 while the PC does not advance (FETCH with ack=0), the selected target SHALL be latched into pend_target and pend_valid set to 1.
REQ-011 pend_valid SHALL clear on the edge at which the PC advances; a new non-00 pcsource during pending SHALL not overwrite the target.
REQ-012 pcsource SHALL be ignored when wpcir=0; ID re-presents it after the stall.
REQ-013 Zero-wait memory (ack in the first request cycle) SHALL sustain one instruction per clock.
REQ-014 Every output SHALL be stable for the whole cycle; imem_req and inst SHALL depend only on state, pc and the memory inputs.

Reset
REQ-015 On resetn=0, asynchronously: pc=0, FSM=FETCH, inst_buf=0, pend_valid=0, pend_target=0.
REQ-016 Immediately after reset: imem_req=1, imem_addr=0, pc_plus_4=4, and inst=0 until the first ack.
REQ-017 Reset during an outstanding fetch SHALL abandon the fetch, with no PC or buffer update; the memory aborts on the same reset.

Structure
REQ-018 A shared package SHALL hold the pcsource encodings (PCS_SEQ=00, PCS_BR=01, PCS_JR=10, PCS_J=11), RESET_PC=32'h0, NOP_INST=32'h0 and the FSM state type.
REQ-019 The combinational next-PC selector SHALL be one sub-module, if_next_pc_mux; all registers SHALL stay in pipe_if_stage.

Verification
REQ-020 Zero-wait memory, wpcir=1, pcsource=00 for 4 cycles -> pc sequence 0,4,8,12; inst = memory words; if_busy=0 throughout.
REQ-021 Two-cycle ack latency at pc=8 -> inst=0 for the first cycle with if_busy=1; ack in the second cycle delivers the word; pc becomes 12 on that edge.
REQ-022 Ack at pc=16 with wpcir=0 for 3 cycles -> HOLD, inst = buffered word each cycle, imem_req=0, pc=16; wpcir=1 -> pc=20, FSM back to FETCH.
REQ-023 pcsource=01 with bpc=32'h100 while the fetch waits (ack=0), then pcsource=00, then ack -> pend_valid set; pc loads 32'h100 on the ack edge.
REQ-024 pc=32'hFFFFFFFC, ack, wpcir=1 -> pc_plus_4=0, and pc wraps to 0.
REQ-025 resetn=0 pulse mid-wait at pc=40 with a pending redirect -> pc=0, pend_valid=0, imem_addr=0 immediately; fetch restarts from 0.

Source files
------------

// File: rtl/pipe_if_stage_pkg.sv
// pipe_if_stage_pkg
//   Shared definitions for the instruction-fetch stage.
//   - pcsource encodings driven by the ID stage
//   - reset PC and the NOP bubble word
//   - fetch FSM state type
package pipe_if_stage_pkg;

   localparam logic [1:0]  PCS_SEQ  = 2'b00;  // pc + 4
   localparam logic [1:0]  PCS_BR   = 2'b01;  // branch target
   localparam logic [1:0]  PCS_JR   = 2'b10;  // jump-register target
   localparam logic [1:0]  PCS_J    = 2'b11;  // jump target

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_INST = 32'h0000_0000;

   typedef enum logic {
      S_FETCH = 1'b0,
      S_HOLD  = 1'b1
   } if_state_e;

endpackage

// File: rtl/if_next_pc_mux.sv
// if_next_pc_mux
//   Combinational next-PC selector. A redirect that arrived while the PC
//   could not advance takes priority over whatever ID presents now.
//   Ports:
//     pcsource     ID next-PC select
//     pc_plus_4    sequential successor of the current pc
//     bpc/rpc/jpc  branch / jump-register / jump targets
//     pend_valid   a redirect is waiting to be applied
//     pend_target  the waiting redirect address
//     next_pc      address the PC loads when it advances
module if_next_pc_mux
   import pipe_if_stage_pkg::*;
(
   input  logic [1:0]  pcsource,
   input  logic [31:0] pc_plus_4,
   input  logic [31:0] bpc,
   input  logic [31:0] rpc,
   input  logic [31:0] jpc,
   input  logic        pend_valid,
   input  logic [31:0] pend_target,
   output logic [31:0] sel_pc,
   output logic [31:0] next_pc
);

   always_comb begin
      sel_pc = pc_plus_4;
      case (pcsource)
         PCS_SEQ: sel_pc = pc_plus_4;
         PCS_BR:  sel_pc = bpc;
         PCS_JR:  sel_pc = rpc;
         PCS_J:   sel_pc = jpc;
         default: sel_pc = pc_plus_4;
      endcase
   end

   assign next_pc = pend_valid ? pend_target : sel_pc;

endmodule

// File: rtl/pipe_if_stage.sv
// pipe_if_stage
//   Instruction-fetch stage: holds the PC, issues fetch requests to an
//   instruction memory with variable latency, buffers a returned word while
//   ID stalls, and remembers a redirect that arrives while a fetch is waiting.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   FETCH  | imem_req=1, waiting for / receiving the word at pc
//   HOLD   | word at pc captured in inst_buf while ID stalls, imem_req=0
//
//   Ports:
//     clock, resetn                clock and async active-low reset
//     wpcir                        1 = PC and IF/ID may advance
//     pcsource, bpc, rpc, jpc      next-PC select and targets from ID
//     imem_req/addr/ack/rdata      instruction memory handshake
//     pc, pc_plus_4, inst          values presented to IF/ID
//     if_busy                      fetch outstanding without ack
module pipe_if_stage
   import pipe_if_stage_pkg::*;
(
   input  logic        clock,
   input  logic        resetn,
   input  logic        wpcir,
   input  logic [1:0]  pcsource,
   input  logic [31:0] bpc,
   input  logic [31:0] rpc,
   input  logic [31:0] jpc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] pc_plus_4,
   output logic [31:0] inst,
   output logic        if_busy
);

   if_state_e   state_q, state_d;
   logic [31:0] pc_q;
   logic [31:0] inst_buf_q;
   logic        pend_valid_q;
   logic [31:0] pend_target_q;

   logic [31:0] pc_plus_4_w;
   logic [31:0] sel_pc;
   logic [31:0] next_pc;
   logic        pc_adv;
   logic        buf_load;
   logic        pend_load;

   assign pc_plus_4_w = pc_q + 32'd4;

   if_next_pc_mux u_next_pc (
      .pcsource    (pcsource),
      .pc_plus_4   (pc_plus_4_w),
      .bpc         (bpc),
      .rpc         (rpc),
      .jpc         (jpc),
      .pend_valid  (pend_valid_q),
      .pend_target (pend_target_q),
      .sel_pc      (sel_pc),
      .next_pc     (next_pc)
   );

   // PC advances when ID accepts and an instruction is available, either
   // just returned from memory or already buffered.
   assign pc_adv   = wpcir && ((state_q == S_HOLD) || imem_ack);
   assign buf_load = (state_q == S_FETCH) && imem_ack && !wpcir;
   // Only the first redirect of a wait is kept; later ones are ignored.
   assign pend_load = (state_q == S_FETCH) && !imem_ack && wpcir &&
                      (pcsource != PCS_SEQ) && !pend_valid_q;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state_q <= S_FETCH;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: if (imem_ack && !wpcir) state_d = S_HOLD;
         S_HOLD:  if (wpcir)              state_d = S_FETCH;
         default:                         state_d = S_FETCH;
      endcase
   end

   always_comb begin
      imem_req = 1'b0;
      if_busy  = 1'b0;
      inst     = NOP_INST;
      case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            if_busy  = !imem_ack;
            inst     = imem_ack ? imem_rdata : NOP_INST;
         end
         S_HOLD: begin
            inst = inst_buf_q;
         end
         default: begin
            inst = NOP_INST;
         end
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pc_q          <= RESET_PC;
         inst_buf_q    <= NOP_INST;
         pend_valid_q  <= 1'b0;
         pend_target_q <= 32'h0;
      end else begin
         if (pc_adv) begin
            pc_q         <= next_pc;
            pend_valid_q <= 1'b0;
         end else if (pend_load) begin
            pend_valid_q  <= 1'b1;
            pend_target_q <= sel_pc;
         end
         if (buf_load) inst_buf_q <= imem_rdata;
      end
   end

   assign pc        = pc_q;
   assign imem_addr = pc_q;
   assign pc_plus_4 = pc_plus_4_w;

endmodule

// File: tb/tb_pipe_if_stage.sv
module tb_pipe_if_stage;

   logic        clock = 1'b0;
   logic        resetn;
   logic        wpcir;
   logic [1:0]  pcsource;
   logic [31:0] bpc, rpc, jpc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] pc, pc_plus_4, inst;
   logic        if_busy;

   pipe_if_stage dut (
      .clock      (clock),
      .resetn     (resetn),
      .wpcir      (wpcir),
      .pcsource   (pcsource),
      .bpc        (bpc),
      .rpc        (rpc),
      .jpc        (jpc),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .pc         (pc),
      .pc_plus_4  (pc_plus_4),
      .inst       (inst),
      .if_busy    (if_busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        req;
      logic [31:0] pc;
      logic [31:0] p4;
      logic [31:0] inst;
      logic        busy;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: what the fetch stage holds, in plain terms.
   logic [31:0] m_pc;
   logic        m_holding;     // a fetched word is parked waiting for ID
   logic [31:0] m_word;
   logic        m_redirect;    // a redirect is remembered
   logic [31:0] m_redirect_to;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   always @(negedge clock) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         check("imem_req",  {31'd0, imem_req}, {31'd0, e.req});
         check("pc",        pc,        e.pc);
         check("imem_addr", imem_addr, e.pc);
         check("pc_plus_4", pc_plus_4, e.p4);
         check("inst",      inst,      e.inst);
         check("if_busy",   {31'd0, if_busy}, {31'd0, e.busy});
      end
   end

   task automatic model_reset();
      m_pc = 32'h0; m_holding = 1'b0; m_word = 32'h0;
      m_redirect = 1'b0; m_redirect_to = 32'h0;
   endtask

   // Drive one cycle of inputs, record what the outputs must be this cycle,
   // then advance the model to what the coming edge does.
   task automatic cycle(input logic ack, input logic w, input logic [1:0] pcs,
                        input logic [31:0] b, input logic [31:0] r,
                        input logic [31:0] j, input logic [31:0] data);
      exp_t        e;
      logic [31:0] target;
      @(posedge clock);
      #1;
      imem_ack = ack; wpcir = w; pcsource = pcs;
      bpc = b; rpc = r; jpc = j; imem_rdata = data;
      e.req  = !m_holding;
      e.pc   = m_pc;
      e.p4   = m_pc + 32'd4;
      e.inst = m_holding ? m_word : (ack ? data : 32'h0);
      e.busy = !m_holding && !ack;
      sb_q.push_back(e);
      case (pcs)
         2'd1:    target = b;
         2'd2:    target = r;
         2'd3:    target = j;
         default: target = m_pc + 32'd4;
      endcase
      if (w && (m_holding || ack)) begin
         m_pc       = m_redirect ? m_redirect_to : target;
         m_redirect = 1'b0;
         m_holding  = 1'b0;
      end else if (!m_holding && ack && !w) begin
         m_holding = 1'b1;
         m_word    = data;
      end else if (!m_holding && !ack && w && pcs != 2'd0 && !m_redirect) begin
         m_redirect    = 1'b1;
         m_redirect_to = target;
      end
   endtask

   task automatic idle_inputs();
      imem_ack = 1'b0; wpcir = 1'b0; pcsource = 2'd0;
      bpc = 32'h0; rpc = 32'h0; jpc = 32'h0; imem_rdata = 32'h0;
   endtask

   // Asynchronous reset between edges; checks are immediate.
   task automatic do_reset();
      @(negedge clock);
      #2;
      idle_inputs();
      resetn = 1'b0;
      #1;
      model_reset();
      check("rst_pc",        pc,        32'h0);
      check("rst_imem_addr", imem_addr, 32'h0);
      check("rst_pc_plus_4", pc_plus_4, 32'h4);
      check("rst_imem_req",  {31'd0, imem_req}, 32'd1);
      check("rst_inst",      inst,      32'h0);
      @(posedge clock);
      @(negedge clock);
      #2;
      resetn = 1'b1;
   endtask

   initial begin
      idle_inputs();
      resetn = 1'b1;
      model_reset();
      #3;
      do_reset();

      // Zero-wait sequential fetch: pc 0,4,8 then 8 waits two cycles.
      cycle(1, 1, 0, 0, 0, 0, 32'hAAAA_0000);
      cycle(1, 1, 0, 0, 0, 0, 32'hAAAA_0004);
      cycle(0, 1, 0, 0, 0, 0, 32'hDEAD_BEEF);
      cycle(1, 1, 0, 0, 0, 0, 32'hAAAA_0008);
      // pc=12 delivered, pc=16 acked under stall -> hold three cycles.
      cycle(1, 1, 0, 0, 0, 0, 32'hAAAA_000C);
      cycle(1, 0, 2'd3, 0, 0, 32'h400, 32'hAAAA_0010);
      cycle(0, 0, 2'd1, 32'h800, 0, 0, 32'h1111_1111);
      cycle(1, 0, 0, 0, 0, 0, 32'h2222_2222);
      cycle(0, 1, 0, 0, 0, 0, 32'h3333_3333);
      // pc=20: redirect while waiting, then plain sequence, then ack.
      cycle(0, 1, 2'd1, 32'h100, 0, 0, 32'h0);
      cycle(0, 1, 2'd2, 0, 32'h300, 0, 32'h0);
      cycle(0, 1, 0, 0, 0, 0, 32'h0);
      cycle(1, 1, 0, 0, 0, 0, 32'hAAAA_0014);
      cycle(1, 1, 0, 0, 0, 0, 32'hBBBB_0100);
      // Wrap at the top of the address space.
      cycle(1, 1, 2'd3, 0, 0, 32'hFFFF_FFFC, 32'hBBBB_0104);
      cycle(1, 1, 0, 0, 0, 0, 32'hCCCC_FFFC);
      cycle(1, 1, 0, 0, 0, 0, 32'hCCCC_0000);
      // Jump to 40, redirect pending, then reset mid-wait.
      cycle(1, 1, 2'd3, 0, 0, 32'd40, 32'hCCCC_0004);
      cycle(0, 1, 2'd1, 32'h200, 0, 0, 32'h0);
      cycle(0, 0, 0, 0, 0, 0, 32'h0);
      do_reset();
      cycle(1, 1, 0, 0, 0, 0, 32'hDDDD_0000);
      cycle(1, 1, 0, 0, 0, 0, 32'hDDDD_0004);

      for (int i = 0; i < 600; i++) begin
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               2'($urandom_range(0, 3)),
               $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
               $urandom & 32'hFFFF_FFFC, $urandom);
         if (i == 300) do_reset();
      end

      @(negedge clock);
      #1;
      check("scoreboard_drained", sb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
